freq_count_reporter: RTL and testbench
======================================

Name: freq_count_reporter

Overview:
- Consumes the result interface of the FrequencyCounter block (ref_sys_cnt, sig_cnt, sig_sys_cnt, ready).
- Snapshots each completed measurement, buffers records in a small FIFO, and serialises them as framed UART packets to the controller MCU.
- Sits in the sys_clk domain between the counter and the MCU UART pin.

Parameters:
- CLKS_PER_BIT, 434: sys_clk cycles per UART bit; legal range is 2 or more.
- FIFO_AW, 2: record FIFO address width; depth is 2**FIFO_AW records.

Ports:
- sys_clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ready  in  1  measurement-complete flag from the counter. Level; only its rising edge matters.
- ref_sys_cnt  in  32  sys_clk count over the reference gate.
- sig_cnt  in  32  signal-clock count over the gate.
- sig_sys_cnt  in  32  sys_clk count over the signal gate.
- uart_tx  out  1  UART 8N1 serial output, LSB first, idle high.
- busy  out  1  high while a frame is being shifted or the FIFO is non-empty.
- overflow  out  1  sticky: at least one record has been dropped since reset.
- drop_cnt  out  8  saturating count of dropped records.

Behaviour:
- Reset values:
  - uart_tx=1, busy=0, overflow=0, drop_cnt=0.
  - FIFO empty, seq=0, FSM in IDLE, ready_q=0.
- Edge detect:
  - ready_q is ready registered.
  - A capture occurs at a clock edge where ready=1 and ready_q=0.
  - ready held high for N cycles yields exactly one capture.
  - ready already high when rst deasserts yields one capture on the first post-reset edge.
- Capture:
  - On the capture edge, write {seq, ref_sys_cnt, sig_cnt, sig_sys_cnt} into the FIFO if it is not full.
  - If the FIFO is full (count sampled before this edge), drop the record:
    - overflow is set.
    - drop_cnt increments, saturating at 0xFF.
    - A pop on the same edge does not rescue the record.
  - seq (8 bit) increments on every capture, dropped or not, and wraps 0xFF to 0x00. The host detects loss from gaps in seq.
- Frame, 15 bytes:
  - byte 0: 0xA5
  - byte 1: seq
  - bytes 2-5: ref_sys_cnt, little-endian
  - bytes 6-9: sig_cnt, little-endian
  - bytes 10-13: sig_sys_cnt, little-endian
  - byte 14: XOR of bytes 1..13
- FSM states: IDLE, LOAD, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into a frame register and go to LOAD.
  - LOAD: load byte[idx] (idx=0 on entry from IDLE) into the shift register, then go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits LSB first, each for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. Then if idx<14, increment idx and go to LOAD; otherwise go to IDLE.
- Timing:
  - Each byte occupies exactly 10*CLKS_PER_BIT+1 cycles; the +1 is the LOAD cycle, during which uart_tx stays 1.
  - A capture into an empty FIFO while in IDLE is popped on the next edge, and the start bit drives on the edge after LOAD. This gives 3 cycles from the capture edge to uart_tx falling.
  - Queued frames follow back-to-back: IDLE lasts 1 cycle between frames.
- busy equals (state != IDLE) or (FIFO count != 0), registered.
- Reset mid-frame:
  - On the rst edge uart_tx returns to 1 immediately and the current frame is aborted; no resumption.
  - FIFO contents are discarded and seq restarts at 0.

Test Plan:
- Single record: CLKS_PER_BIT=4, ref_sys_cnt=0x01020304, sig_cnt=0x0A0B0C0D, sig_sys_cnt=0x11223344, one ready pulse. Required response:
  - Decoded bytes are A5 00 04 03 02 01 0D 0C 0B 0A 44 33 22 11 40.
  - uart_tx falls 3 cycles after the capture edge.
  - The frame spans 15*41=615 cycles, after which busy=0.
- Level ready: ready held high 50 cycles, then low, then high again. Required response:
  - Exactly 2 frames are sent, with seq 00 and 01.
  - drop_cnt=0.
- Overflow: FIFO_AW=1, CLKS_PER_BIT=4, five ready pulses spaced 3 cycles apart. Required response:
  - Frames are sent with seq 00, 01, 02 only.
  - overflow=1 and drop_cnt=2.
  - A following capture is sent with seq 05.
- Sequence wrap and saturation: 257 captures with spacing greater than the frame time. Required response:
  - The last two frames carry seq FF then 00.
  - A separate burst forcing 300 drops leaves drop_cnt=0xFF.
- Reset mid-frame: assert rst for 1 cycle during byte 5. Required response:
  - uart_tx=1 on the next edge; busy=0; overflow=0.
  - No further bits are sent.
  - The next capture produces a complete frame with seq 00.
- Capture on the same edge as a pop with the FIFO full: the record is dropped and drop_cnt increments by 1.

Source files
------------

// File: rtl/freq_count_reporter.sv
// -----------------------------------------------------------------------------
// freq_count_reporter
// Snapshots each completed FrequencyCounter measurement, buffers the records
// in a small FIFO and sends each one to the controller MCU as a framed 8N1 UART
// packet (LSB first, idle high).
//
// Frame (15 bytes): A5, seq, ref_sys_cnt[LE], sig_cnt[LE], sig_sys_cnt[LE],
//                   XOR of bytes 1..13.
//
// Ports:
//   sys_clk      in   system clock, all logic on its rising edge
//   rst          in   synchronous active-high reset
//   ready        in   measurement-complete level; its rising edge captures
//   ref_sys_cnt  in   [31:0] sys_clk count over the reference gate
//   sig_cnt      in   [31:0] signal-clock count over the gate
//   sig_sys_cnt  in   [31:0] sys_clk count over the signal gate
//   uart_tx      out  UART serial output, registered
//   busy         out  frame in progress or FIFO non-empty, registered
//   overflow     out  sticky: a record was dropped since reset
//   drop_cnt     out  [7:0] saturating count of dropped records
// -----------------------------------------------------------------------------
module freq_count_reporter #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 2
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        ready,
    input  logic [31:0] ref_sys_cnt,
    input  logic [31:0] sig_cnt,
    input  logic [31:0] sig_sys_cnt,
    output logic        uart_tx,
    output logic        busy,
    output logic        overflow,
    output logic [7:0]  drop_cnt
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] ZERO_CNT = {(FIFO_AW + 1){1'b0}};
    localparam logic [CW-1:0]    BIT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    // Record layout: {seq[103:96], ref_sys_cnt[95:64], sig_cnt[63:32], sig_sys_cnt[31:0]}
    logic [103:0]       mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r;
    logic [FIFO_AW-1:0] rd_ptr_r;
    logic [FIFO_AW:0]   count_r;
    logic               ready_q_r;
    logic [7:0]         seq_r;

    logic [103:0]       frame_r;
    logic [3:0]         idx_r;
    logic [7:0]         shreg_r;
    logic [2:0]         bit_idx_r;
    logic [CW-1:0]      clk_cnt_r;
    state_t             state_r;
    state_t             state_next_s;

    logic               capture_s;
    logic               fifo_full_s;
    logic               push_s;
    logic               pop_s;
    logic               bit_done_s;
    logic               uart_tx_next_s;
    logic               busy_next_s;

    // XOR of all 13 record bytes, which equals the XOR of frame bytes 1..13.
    function automatic logic [7:0] record_xor(input logic [103:0] rec);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 13; i++) begin
            acc = acc ^ rec[8*i +: 8];
        end
        return acc;
    endfunction

    // Byte i of the outgoing frame built from a stored record.
    function automatic logic [7:0] frame_byte(input logic [103:0] rec, input logic [3:0] i);
        logic [7:0] b;
        case (i)
            4'd0:    b = 8'hA5;
            4'd1:    b = rec[103:96];
            4'd2:    b = rec[71:64];
            4'd3:    b = rec[79:72];
            4'd4:    b = rec[87:80];
            4'd5:    b = rec[95:88];
            4'd6:    b = rec[39:32];
            4'd7:    b = rec[47:40];
            4'd8:    b = rec[55:48];
            4'd9:    b = rec[63:56];
            4'd10:   b = rec[7:0];
            4'd11:   b = rec[15:8];
            4'd12:   b = rec[23:16];
            4'd13:   b = rec[31:24];
            4'd14:   b = record_xor(rec);
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

    // Fullness is judged on the count before the edge, so a same-edge pop
    // cannot make room for a capture.
    assign capture_s   = ready & ~ready_q_r;
    assign fifo_full_s = (count_r == FULL_CNT);
    assign push_s      = capture_s & ~fifo_full_s;
    assign pop_s       = (state_r == IDLE) && (count_r != ZERO_CNT);
    assign bit_done_s  = (clk_cnt_r == BIT_LAST);

    // Record storage; contents are don't-care until written, so no reset.
    always_ff @(posedge sys_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {seq_r, ref_sys_cnt, sig_cnt, sig_sys_cnt};
        end
    end

    // Edge detect, sequence number, FIFO pointers and drop accounting.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            ready_q_r <= 1'b0;
            seq_r     <= 8'h00;
            wr_ptr_r  <= {FIFO_AW{1'b0}};
            rd_ptr_r  <= {FIFO_AW{1'b0}};
            count_r   <= ZERO_CNT;
            overflow  <= 1'b0;
            drop_cnt  <= 8'h00;
        end else begin
            ready_q_r <= ready;
            if (capture_s) begin
                seq_r <= seq_r + 8'h01;
                if (fifo_full_s) begin
                    overflow <= 1'b1;
                    if (drop_cnt != 8'hFF) begin
                        drop_cnt <= drop_cnt + 8'h01;
                    end
                end
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + FIFO_AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (FIFO_AW + 1)'(1);
                2'b01:   count_r <= count_r - (FIFO_AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Transmit FSM state register.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Transmit FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (count_r != ZERO_CNT) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: state_next_s = START;
            START: begin
                if (bit_done_s) begin
                    state_next_s = DATA;
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (bit_done_s && (bit_idx_r == 3'd7)) begin
                    state_next_s = STOP;
                end else begin
                    state_next_s = DATA;
                end
            end
            STOP: begin
                if (!bit_done_s) begin
                    state_next_s = STOP;
                end else if (idx_r != 4'd14) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Transmit FSM output decode, registered below.
    always_comb begin
        uart_tx_next_s = 1'b1;
        case (state_r)
            START:   uart_tx_next_s = 1'b0;
            DATA:    uart_tx_next_s = shreg_r[0];
            default: uart_tx_next_s = 1'b1;
        endcase
        busy_next_s = (state_r != IDLE) || (count_r != ZERO_CNT);
    end

    // Registered outputs; reset returns the line to idle on the reset edge.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            uart_tx <= 1'b1;
            busy    <= 1'b0;
        end else begin
            uart_tx <= uart_tx_next_s;
            busy    <= busy_next_s;
        end
    end

    // Frame register, byte index, shift register and bit timing.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            frame_r   <= 104'h0;
            idx_r     <= 4'd0;
            shreg_r   <= 8'hFF;
            bit_idx_r <= 3'd0;
            clk_cnt_r <= {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    clk_cnt_r <= {CW{1'b0}};
                    idx_r     <= 4'd0;
                    if (pop_s) begin
                        frame_r <= mem_r[rd_ptr_r];
                    end
                end
                LOAD: begin
                    clk_cnt_r <= {CW{1'b0}};
                    bit_idx_r <= 3'd0;
                    shreg_r   <= frame_byte(frame_r, idx_r);
                end
                START: begin
                    clk_cnt_r <= bit_done_s ? {CW{1'b0}} : clk_cnt_r + CW'(1);
                end
                DATA: begin
                    clk_cnt_r <= bit_done_s ? {CW{1'b0}} : clk_cnt_r + CW'(1);
                    if (bit_done_s) begin
                        shreg_r   <= {1'b1, shreg_r[7:1]};
                        bit_idx_r <= bit_idx_r + 3'd1;
                    end
                end
                STOP: begin
                    clk_cnt_r <= bit_done_s ? {CW{1'b0}} : clk_cnt_r + CW'(1);
                    if (bit_done_s && (idx_r != 4'd14)) begin
                        idx_r <= idx_r + 4'd1;
                    end
                end
                default: clk_cnt_r <= {CW{1'b0}};
            endcase
        end
    end

endmodule

// File: tb/tb_freq_count_reporter.sv
// -----------------------------------------------------------------------------
// Testbench for freq_count_reporter (CLKS_PER_BIT=4, FIFO_AW=1).
// A transaction-level reference model (record queue plus "transmitter free
// from edge N" arithmetic) predicts which records are sent or dropped; a UART
// decoder rebuilds frames from uart_tx and both sides are compared.
// -----------------------------------------------------------------------------
module tb_freq_count_reporter;

    localparam int CPB       = 4;
    localparam int AW        = 1;
    localparam int DEPTH     = 2;
    localparam int FRAME_CYC = 15 * (10 * CPB + 1);
    localparam int POP_GAP   = FRAME_CYC + 1;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        ready;
    logic [31:0] ref_sys_cnt;
    logic [31:0] sig_cnt;
    logic [31:0] sig_sys_cnt;
    logic        uart_tx;
    logic        busy;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [103:0] m_q[$];
    logic [119:0] exp_frames[$];
    logic [7:0]   m_seq = 8'h00;
    logic         m_rq = 1'b0;
    logic         m_ovf = 1'b0;
    int           m_drop = 0;
    int           m_edge = 0;
    int           m_next_pop = 0;

    // decoder state
    logic [119:0] got_frames[$];
    logic [7:0]   d_buf[$];
    logic [7:0]   d_byte = 8'h00;
    logic [119:0] d_frame;
    logic         d_active = 1'b0;
    int           d_cnt = 0;
    int           d_bit = 0;
    int           d_ferr = 0;
    int           low_cnt = 0;
    int           low_snap = 0;

    freq_count_reporter #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .ready       (ready),
        .ref_sys_cnt (ref_sys_cnt),
        .sig_cnt     (sig_cnt),
        .sig_sys_cnt (sig_sys_cnt),
        .uart_tx     (uart_tx),
        .busy        (busy),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // UART receiver: samples mid-bit on falling clock edges.
    always @(negedge sys_clk) begin
        if (uart_tx === 1'b0) low_cnt++;
        if (rst === 1'b1) begin
            d_active = 1'b0;
            d_buf.delete();
        end else if (!d_active) begin
            if (uart_tx === 1'b0) begin
                d_active = 1'b1;
                d_cnt = 0;
            end
        end else begin
            d_cnt++;
            if ((d_cnt % CPB) == (CPB / 2)) begin
                d_bit = d_cnt / CPB;
                if (d_bit == 0) begin
                    if (uart_tx !== 1'b0) begin
                        d_active = 1'b0;
                        d_ferr++;
                    end
                end else if (d_bit <= 8) begin
                    d_byte[d_bit-1] = uart_tx;
                end else begin
                    if (uart_tx !== 1'b1) d_ferr++;
                    d_active = 1'b0;
                    d_buf.push_back(d_byte);
                    if (d_buf.size() == 15) begin
                        d_frame = '0;
                        for (int i = 0; i < 15; i++) d_frame = (d_frame << 8) | 120'(d_buf[i]);
                        got_frames.push_back(d_frame);
                        d_buf.delete();
                    end
                end
            end
        end
    end

    function automatic logic [119:0] make_frame(input logic [103:0] rec);
        logic [7:0]   b[15];
        logic [31:0]  w0, w1, w2;
        logic [119:0] f;
        w0 = rec[95:64];
        w1 = rec[63:32];
        w2 = rec[31:0];
        b[0] = 8'hA5;
        b[1] = rec[103:96];
        for (int i = 0; i < 4; i++) begin
            b[2+i]  = 8'((w0 >> (8 * i)) & 32'hFF);
            b[6+i]  = 8'((w1 >> (8 * i)) & 32'hFF);
            b[10+i] = 8'((w2 >> (8 * i)) & 32'hFF);
        end
        b[14] = 8'h00;
        for (int i = 1; i <= 13; i++) b[14] = b[14] ^ b[i];
        f = '0;
        for (int i = 0; i < 15; i++) f = (f << 8) | 120'(b[i]);
        return f;
    endfunction

    // Advances the model by one clock edge using the inputs seen at that edge.
    task automatic model_update();
        int   cnt;
        logic cap;
        if (rst) begin
            if ((m_edge < m_next_pop - 1) && (exp_frames.size() > 0)) void'(exp_frames.pop_back());
            m_q.delete();
            m_seq = 8'h00;
            m_rq = 1'b0;
            m_ovf = 1'b0;
            m_drop = 0;
            m_next_pop = m_edge + 1;
        end else begin
            cnt = m_q.size();
            cap = ready && !m_rq;
            m_rq = ready;
            if ((cnt > 0) && (m_edge >= m_next_pop)) begin
                exp_frames.push_back(make_frame(m_q.pop_front()));
                m_next_pop = m_edge + POP_GAP;
            end
            if (cap) begin
                if (cnt == DEPTH) begin
                    m_ovf = 1'b1;
                    if (m_drop < 255) m_drop++;
                end else begin
                    m_q.push_back({m_seq, ref_sys_cnt, sig_cnt, sig_sys_cnt});
                end
                m_seq = m_seq + 8'h01;
            end
        end
        m_edge++;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rdy);
        ready = rdy;
        @(posedge sys_clk);
        model_update();
        #1;
    endtask

    task automatic pulse();
        ref_sys_cnt = $urandom();
        sig_cnt     = $urandom();
        sig_sys_cnt = $urandom();
        step(1'b1);
        step(1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while ((busy !== 1'b0) && (k < 20000)) begin
            step(1'b0);
            k++;
        end
        check({tag, "_idle"}, 128'(busy), 128'(1'b0));
        repeat (4) step(1'b0);
    endtask

    function automatic logic [7:0] got_seq(input int i);
        logic [7:0] r;
        r = 8'hxx;
        if (i < got_frames.size()) r = got_frames[i][111:104];
        return r;
    endfunction

    task automatic compare_frames(input string tag);
        int n;
        check({tag, "_nframes"}, 128'(got_frames.size()), 128'(exp_frames.size()));
        n = (got_frames.size() < exp_frames.size()) ? got_frames.size() : exp_frames.size();
        for (int i = 0; i < n; i++) check({tag, "_frame"}, 128'(got_frames[i]), 128'(exp_frames[i]));
        check({tag, "_drop_model"}, 128'(drop_cnt), 128'(m_drop));
        check({tag, "_ovf_model"}, 128'(overflow), 128'(m_ovf));
        got_frames.delete();
        exp_frames.delete();
    endtask

    initial begin
        rst = 1'b1;
        ready = 1'b0;
        ref_sys_cnt = 32'h0;
        sig_cnt = 32'h0;
        sig_sys_cnt = 32'h0;
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
        check("rst_uart_tx", 128'(uart_tx), 128'(1'b1));
        check("rst_busy", 128'(busy), 128'(1'b0));
        check("rst_overflow", 128'(overflow), 128'(1'b0));
        check("rst_drop_cnt", 128'(drop_cnt), 128'(8'h00));

        // single record: latency, exact bytes, frame length
        ref_sys_cnt = 32'h01020304;
        sig_cnt     = 32'h0A0B0C0D;
        sig_sys_cnt = 32'h11223344;
        step(1'b1);
        check("t1_tx_e0", 128'(uart_tx), 128'(1'b1));
        step(1'b1);
        step(1'b1);
        check("t1_tx_e2", 128'(uart_tx), 128'(1'b1));
        step(1'b0);
        check("t1_tx_fall", 128'(uart_tx), 128'(1'b0));
        repeat (613) step(1'b0);
        check("t1_busy_last", 128'(busy), 128'(1'b1));
        step(1'b0);
        check("t1_busy_end", 128'(busy), 128'(1'b0));
        repeat (4) step(1'b0);
        check("t1_bytes", 128'(got_seq(0) === 8'h00 ? got_frames[0] : 120'h0),
              128'(120'hA5_00_04_03_02_01_0D_0C_0B_0A_44_33_22_11_40));
        compare_frames("t1");

        // level ready, already high as reset releases
        ref_sys_cnt = $urandom();
        sig_cnt     = $urandom();
        sig_sys_cnt = $urandom();
        rst = 1'b1;
        step(1'b1);
        step(1'b1);
        rst = 1'b0;
        repeat (50) step(1'b1);
        repeat (5) step(1'b0);
        ref_sys_cnt = $urandom();
        repeat (5) step(1'b1);
        step(1'b0);
        wait_idle("t2");
        check("t2_count", 128'(got_frames.size()), 128'(2));
        check("t2_seq0", 128'(got_seq(0)), 128'(8'h00));
        check("t2_seq1", 128'(got_seq(1)), 128'(8'h01));
        check("t2_drop", 128'(drop_cnt), 128'(8'h00));
        compare_frames("t2");

        // overflow: five captures 3 cycles apart into a 2-deep FIFO
        do_reset();
        repeat (5) begin
            pulse();
            step(1'b0);
        end
        check("t3_overflow", 128'(overflow), 128'(1'b1));
        check("t3_drop", 128'(drop_cnt), 128'(8'h02));
        wait_idle("t3");
        check("t3_count", 128'(got_frames.size()), 128'(3));
        check("t3_seq0", 128'(got_seq(0)), 128'(8'h00));
        check("t3_seq1", 128'(got_seq(1)), 128'(8'h01));
        check("t3_seq2", 128'(got_seq(2)), 128'(8'h02));
        compare_frames("t3a");
        pulse();
        wait_idle("t3b");
        check("t3_seq5", 128'(got_seq(0)), 128'(8'h05));
        compare_frames("t3b");

        // capture on the same edge as a pop with the FIFO full
        do_reset();
        pulse();
        pulse();
        pulse();
        repeat (611) step(1'b0);
        check("t4_drop_before", 128'(drop_cnt), 128'(8'h00));
        pulse();
        check("t4_drop_after", 128'(drop_cnt), 128'(8'h01));
        wait_idle("t4");
        check("t4_count", 128'(got_frames.size()), 128'(3));
        compare_frames("t4");

        // sequence wrap: 253 burst captures, then four spaced ones
        do_reset();
        repeat (253) pulse();
        wait_idle("t5a");
        compare_frames("t5a");
        repeat (4) begin
            pulse();
            wait_idle("t5b");
        end
        check("t5_count", 128'(got_frames.size()), 128'(4));
        check("t5_seq_ff", 128'(got_seq(2)), 128'(8'hFF));
        check("t5_seq_00", 128'(got_seq(3)), 128'(8'h00));
        compare_frames("t5b");

        // drop counter saturation
        do_reset();
        repeat (305) pulse();
        check("t6_drop_sat", 128'(drop_cnt), 128'(8'hFF));
        check("t6_overflow", 128'(overflow), 128'(1'b1));
        wait_idle("t6");
        compare_frames("t6");

        // reset during byte 5 of a frame
        pulse();
        repeat (228) step(1'b0);
        rst = 1'b1;
        step(1'b0);
        check("t7_tx", 128'(uart_tx), 128'(1'b1));
        check("t7_busy", 128'(busy), 128'(1'b0));
        check("t7_overflow", 128'(overflow), 128'(1'b0));
        check("t7_drop", 128'(drop_cnt), 128'(8'h00));
        rst = 1'b0;
        low_snap = low_cnt;
        repeat (700) step(1'b0);
        check("t7_quiet", 128'(low_cnt), 128'(low_snap));
        check("t7_no_frame", 128'(got_frames.size()), 128'(0));
        compare_frames("t7a");
        pulse();
        wait_idle("t7b");
        check("t7_count", 128'(got_frames.size()), 128'(1));
        check("t7_seq", 128'(got_seq(0)), 128'(8'h00));
        compare_frames("t7b");

        check("uart_framing", 128'(d_ferr), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
